// File: rtl/counter_4_bit_down_reload.sv
// Prescaled 4-bit down-counter with parallel load and optional auto-reload.
// Counts a loaded value down to zero, pulsing tc on the tick that ends each period.
module counter_4_bit_down_reload #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       auto_reload,
  output logic [3:0] counter,
  output logic       tick,
  output logic       tc,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t          state;
  logic [3:0]      reload_reg;
  logic [PS_W-1:0] prescaler;
  logic            ps_wrap;

  assign ps_wrap = (prescaler == PS_LAST);

  // busy is registered next to state so it always equals (state == RUN).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
      tick       <= 1'b0;
      tc         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tick <= 1'b0;
      tc   <= 1'b0;
      if (load) begin
        // Load wins over any tick, reload or terminal count in the same cycle.
        counter    <= load_val;
        reload_reg <= load_val;
        prescaler  <= '0;
        if (load_val != 4'd0) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= DONE;
          busy  <= 1'b0;
        end
      end else if (state == RUN && en) begin
        if (ps_wrap) begin
          prescaler <= '0;
          tick      <= 1'b1;
          if (counter > 4'd1) begin
            counter <= counter - 4'd1;
          end else begin
            // auto_reload is sampled here, at the end of the period.
            tc <= 1'b1;
            if (auto_reload) begin
              counter <= reload_reg;
            end else begin
              counter <= '0;
              state   <= DONE;
              busy    <= 1'b0;
            end
          end
        end else begin
          prescaler <= prescaler + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_4_bit_down_reload.sv
// Bench for counter_4_bit_down_reload: directed scenarios then random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_counter_4_bit_down_reload;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       auto_reload = 1'b0;
  logic [3:0] counter;
  logic       tick;
  logic       tc;
  logic       busy;

  counter_4_bit_down_reload #(.PRESCALE(P), .PS_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .auto_reload(auto_reload), .counter(counter), .tick(tick), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: remaining count, reload value, enabled cycles into current tick period.
  int  m_cnt, m_rel, m_phase;
  bit  m_running, m_tick, m_tc;
  logic [6:0] exp_q[$];

  int tc_seen, tick_at, tc_at, busy_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_phase = 0;
    m_running = 0; m_tick = 0; m_tc = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_tc   = 0;
    if (load) begin
      m_cnt = load_val; m_rel = load_val; m_phase = 0;
      m_running = (load_val != 0);
    end else if (m_running && en) begin
      m_phase = (m_phase + 1) % P;
      if (m_phase == 0) begin
        m_tick = 1;
        m_cnt  = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1;
          if (auto_reload) m_cnt = m_rel;
          else m_running = 0;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    exp_q.push_back({m_running, m_tc, m_tick, m_cnt[3:0]});
    #1;
    check(tag, {busy, tc, tick, counter}, exp_q.pop_front());
  endtask

  task automatic do_load(input logic [3:0] v, input logic ar);
    load = 1'b1; load_val = v; auto_reload = ar;
    step("load");
    load = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held with a load request pending: nothing may leave zero.
    rst = 1'b0; load = 1'b1; load_val = 4'd9;
    repeat (3) step("reset_hold");
    load = 1'b0; rst = 1'b1;

    // One-shot count of 3.
    en = 1'b1;
    do_load(4'd3, 1'b0);
    tc_seen = 0; tc_at = -1;
    for (int i = 1; i <= 32; i++) begin
      step("oneshot");
      if (tc) begin tc_seen++; tc_at = i; end
    end
    check("oneshot_tc_cycle", tc_at, 12);
    check("oneshot_tc_count", tc_seen, 1);
    check("oneshot_final", {busy, counter}, 5'h00);

    // Auto-reload of 2.
    do_load(4'd2, 1'b1);
    tc_seen = 0; busy_low = 0;
    for (int i = 1; i <= 24; i++) begin
      step("autoreload");
      if (tc) tc_seen++;
      if (!busy) busy_low++;
      if (i % 4 == 0) check("autoreload_seq", counter, (i % 8 == 0) ? 2 : 1);
    end
    check("autoreload_tc_count", tc_seen, 3);
    check("autoreload_busy_low", busy_low, 0);

    // Enable gating mid-prescale.
    do_load(4'd5, 1'b0);
    repeat (6) step("gate_pre");
    check("gate_count_before", counter, 4);
    en = 1'b0;
    repeat (7) step("gate_frozen");
    check("gate_count_frozen", counter, 4);
    en = 1'b1;
    tick_at = -1;
    for (int i = 1; i <= 10 && tick_at < 0; i++) begin
      step("gate_resume");
      if (tick) tick_at = i;
    end
    check("gate_resume_tick", tick_at, 2);
    check("gate_resume_count", counter, 3);

    // Load on the same cycle as a terminal-count tick.
    do_load(4'd2, 1'b1);
    repeat (7) step("collide_pre");
    do_load(4'd7, 1'b1);
    check("collide_state", {tc, tick, counter}, 6'h07);
    tick_at = -1;
    for (int i = 1; i <= 10 && tick_at < 0; i++) begin
      step("collide_next");
      if (tick) tick_at = i;
    end
    check("collide_next_tick", tick_at, 4);
    check("collide_count", counter, 6);

    // Asynchronous reset between edges.
    #3 rst = 1'b0;
    #1 model_reset();
    check("async_reset", {busy, tc, tick, counter}, 7'h00);
    step("async_reset_edge");
    rst = 1'b1;
    do_load(4'd0, 1'b1);
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step("zero_load");
      if (tc) tc_seen++;
    end
    check("zero_load_tc", tc_seen, 0);
    check("zero_load_state", {busy, counter}, 5'h00);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      load        = ($urandom_range(0, 11) == 0);
      load_val    = 4'($urandom_range(0, 15));
      auto_reload = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 199) != 0);
      step("random");
    end
    rst = 1'b1; load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_4_bit_down_reload.md
Name: counter_4_bit_down_reload

Overview:
- 4-bit prescaled down-counter with parallel load and optional auto-reload.
- It is the counterpart of the existing 4-bit up-counter: it counts a loaded value down to zero and flags terminal count.
- Used as a programmable interval timer/event divider beside the up-counter in the counter lab datapath.
- On board builds the prescaler slows the visible count rate.

Parameters:
- PRESCALE, 4, clk cycles per count tick (>=1); PRESCALE=1 means tick every enabled cycle
- PS_W, 2, prescaler width; must satisfy 2^PS_W >= PRESCALE

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable; gates prescaler and counter
- load  input  1  synchronous parallel load strobe
- load_val  input  4  value loaded into counter and reload register
- auto_reload  input  1  1: reload on reaching zero; 0: stop at zero
- counter  output  4  current count
- tick  output  1  one-cycle pulse each prescaled count event
- tc  output  1  one-cycle terminal-count pulse
- busy  output  1  high in RUN state

Behaviour:
- Reset (rst=0, asynchronous): counter=0, reload_reg=0, prescaler=0, state=IDLE, tick=0, tc=0, busy=0.
- Reset deassertion is sampled synchronously; the first active edge is the first clk edge with rst=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on load with load_val!=0.
  - IDLE -> DONE on load with load_val==0.
  - RUN -> DONE on tick at counter==1 when auto_reload=0.
  - RUN stays in RUN on tick at counter==1 when auto_reload=1.
  - DONE -> RUN/DONE on load, using the same rule as IDLE.
- Load (any state, synchronous): counter<=load_val, reload_reg<=load_val, prescaler<=0, tick/tc not asserted that cycle.
- Load has priority over en/tick. This includes reload and terminal-count events in the same cycle.
- Prescaler: increments only when en=1 and state=RUN.
  - At PRESCALE-1 it wraps to 0 and asserts tick for exactly that cycle, registered and aligned with the counter update.
  - en=0 freezes the prescaler and counter (no clear).
- On tick in RUN:
  - counter>1: counter<=counter-1.
  - counter==1: tc=1 that cycle.
    - auto_reload=1: counter<=reload_reg, remain RUN.
    - auto_reload=0: counter<=0, go to DONE.
- Terminal count is taken at the 1->0 transition, so tc aligns with the tick that ends the period.
- Period with auto-reload is load_val*PRESCALE enabled cycles.
- auto_reload is sampled at the tick that reaches terminal count, not at load.
- busy=1 iff state==RUN.
- Outputs counter, tick, tc and busy are all registered.
- No underflow: counter never wraps 0->15, and DONE/IDLE ignore en.
- load_val==0 enters DONE with counter=0 and never asserts tc.
- Reset mid-count immediately clears everything; the reload value is lost.

Test Plan:
- Reset: hold rst=0 for 3 cycles while load=1, load_val=9 -> counter=0, busy=0, tick=0, tc=0 throughout.
- One-shot: PRESCALE=4, load 3, en=1, auto_reload=0.
  - counter steps 3->2->1->0 every 4 cycles.
  - tc one cycle at the 1->0 edge (cycle 12 after load).
  - busy drops; counter holds 0 for 20 more cycles.
- Auto-reload: load 2, auto_reload=1, en=1.
  - Sequence 2,1,2,1,2, with tc every 8 cycles and exactly 3 tc pulses in 24 cycles.
  - busy stays high.
- Enable gating: load 5, drop en for 7 cycles mid-prescale -> counter and prescaler frozen; resumes with no lost or extra tick.
- Load collision: assert load with load_val=7 on the same cycle as a terminal-count tick -> counter=7, tc=0, prescaler=0, next tick 4 cycles later.
- Async reset mid-run: pull rst low between clock edges while counter=6 -> counter=0 and busy=0 before the next edge; load_val=0 after reset -> DONE, no tc.
